// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - next-PC select and FSM state encodings shared by the PC unit
package pc_pkg;

  typedef logic [2:0] pc_sel_t;

  localparam pc_sel_t PC_SEL_REDIR = 3'd0;
  localparam pc_sel_t PC_SEL_HOLD  = 3'd1;
  localparam pc_sel_t PC_SEL_BR    = 3'd2;
  localparam pc_sel_t PC_SEL_JMP   = 3'd3;
  localparam pc_sel_t PC_SEL_RET   = 3'd4;
  localparam pc_sel_t PC_SEL_SEQ   = 3'd5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; a push on a full stack overwrites the oldest entry
module pc_ras #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clr,
  input  logic [W-1:0]               push_data,
  output logic [W-1:0]               top,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf
);
  import pc_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;

  // wp is the next free slot, so the top of stack sits just below it
  assign top = mem[wp - PW'(1)];

  always_ff @(posedge clk) begin
    if (!rst && !clr && push) begin
      mem[wp] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      wp    <= '0;
      count <= '0;
    end else if (push) begin
      wp <= wp + PW'(1);
      if (count == FULL) begin
        ovf <= 1'b1;
      end else begin
        count <= count + (PW+1)'(1);
      end
    end else if (pop && (count != '0)) begin
      wp    <= wp - PW'(1);
      count <= count - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-address generator: PC register, run/idle FSM, next-PC priority mux and RAS
module pc_unit #(
  parameter int                ADDR_W       = 32,
  parameter int                INC          = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                RAS_DEPTH    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stall,
  input  logic                         redirect_i,
  input  logic [ADDR_W-1:0]            redirect_addr_i,
  input  logic                         branch_i,
  input  logic [ADDR_W-1:0]            branch_addr_i,
  input  logic                         jump_i,
  input  logic                         call_i,
  input  logic [ADDR_W-1:0]            jump_addr_i,
  input  logic                         ret_i,
  input  logic [ADDR_W-1:0]            ret_addr_i,
  output logic [ADDR_W-1:0]            pc_o,
  output logic [ADDR_W-1:0]            pc_next_o,
  output logic                         running_o,
  output logic [$clog2(RAS_DEPTH):0]   ras_count_o,
  output logic                         ras_ovf_o
);
  import pc_pkg::*;

  logic [0:0]        state;
  pc_sel_t           sel;
  logic              active;
  logic              ras_push;
  logic              ras_pop;
  logic              ras_clr;
  logic              ras_empty;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] ras_top;

  assign running_o = (state == ST_RUN);
  assign active    = running_o && start;
  assign pc_seq    = pc_o + ADDR_W'(INC);
  assign ras_empty = (ras_count_o == '0);

  always_comb begin
    sel = PC_SEL_SEQ;
    if (redirect_i)    sel = PC_SEL_REDIR;
    else if (stall)    sel = PC_SEL_HOLD;
    else if (branch_i) sel = PC_SEL_BR;
    else if (jump_i)   sel = PC_SEL_JMP;
    else if (ret_i)    sel = PC_SEL_RET;
  end

  // RAS side effects only for the request that actually wins the mux
  assign ras_push = active && (sel == PC_SEL_JMP) && call_i;
  assign ras_pop  = active && (sel == PC_SEL_RET) && !ras_empty;
  assign ras_clr  = running_o && !start;

  always_comb begin
    pc_next_o = RESET_VECTOR;
    if (active) begin
      case (sel)
        PC_SEL_REDIR: pc_next_o = redirect_addr_i;
        PC_SEL_HOLD:  pc_next_o = pc_o;
        PC_SEL_BR:    pc_next_o = branch_addr_i;
        PC_SEL_JMP:   pc_next_o = jump_addr_i;
        PC_SEL_RET:   pc_next_o = ras_empty ? ret_addr_i : ras_top;
        default:      pc_next_o = pc_seq;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      pc_o  <= RESET_VECTOR;
    end else begin
      state <= start ? ST_RUN : ST_IDLE;
      pc_o  <= pc_next_o;
    end
  end

  pc_ras #(
    .W     (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .clr       (ras_clr),
    .push_data (pc_seq),
    .top       (ras_top),
    .count     (ras_count_o),
    .ovf       (ras_ovf_o)
  );

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit with a queue-based reference model
module tb_pc_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, stall, redirect, branch, jump, call, ret;
  logic [31:0] redirect_addr, branch_addr, jump_addr, ret_addr;
  logic [31:0] pc, pc_next;
  logic        running, ras_ovf;
  logic [3:0]  ras_count;

  logic        start2;
  logic [15:0] pc2, pc_next2;
  logic        running2, ras_ovf2;
  logic [3:0]  ras_count2;

  int n_checks = 0;
  int n_errors = 0;

  pc_unit #(.ADDR_W(32), .INC(4), .RESET_VECTOR(32'h0), .RAS_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .redirect_i(redirect), .redirect_addr_i(redirect_addr),
    .branch_i(branch), .branch_addr_i(branch_addr),
    .jump_i(jump), .call_i(call), .jump_addr_i(jump_addr),
    .ret_i(ret), .ret_addr_i(ret_addr),
    .pc_o(pc), .pc_next_o(pc_next), .running_o(running),
    .ras_count_o(ras_count), .ras_ovf_o(ras_ovf)
  );

  pc_unit #(.ADDR_W(16), .INC(4), .RESET_VECTOR(16'hFFF4), .RAS_DEPTH(8)) dut16 (
    .clk(clk), .rst(rst), .start(start2), .stall(1'b0),
    .redirect_i(1'b0), .redirect_addr_i(16'h0),
    .branch_i(1'b0), .branch_addr_i(16'h0),
    .jump_i(1'b0), .call_i(1'b0), .jump_addr_i(16'h0),
    .ret_i(1'b0), .ret_addr_i(16'h0),
    .pc_o(pc2), .pc_next_o(pc_next2), .running_o(running2),
    .ras_count_o(ras_count2), .ras_ovf_o(ras_ovf2)
  );

  // reference model: architectural PC, run flag, RAS as a queue (back = top)
  logic [31:0] m_pc = 32'h0;
  bit          m_run = 1'b0;
  bit          m_ovf = 1'b0;
  logic [31:0] m_ras[$];

  function automatic logic [31:0] predict_pc();
    if (!m_run || !start) return 32'h0;
    if (redirect) return redirect_addr;
    if (stall)    return m_pc;
    if (branch)   return branch_addr;
    if (jump)     return jump_addr;
    if (ret)      return (m_ras.size() > 0) ? m_ras[$] : ret_addr;
    return m_pc + 32'd4;
  endfunction

  task automatic model_edge();
    logic [31:0] nxt;
    nxt = predict_pc();
    if (rst) begin
      m_pc = 32'h0; m_run = 1'b0; m_ovf = 1'b0; m_ras.delete();
    end else if (!m_run) begin
      m_pc = 32'h0; m_run = start;
    end else if (!start) begin
      m_pc = 32'h0; m_run = 1'b0; m_ras.delete();
    end else begin
      if (!redirect && !stall && !branch) begin
        if (jump && call) begin
          m_ras.push_back(m_pc + 32'd4);
          if (m_ras.size() > 8) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
        end else if (!jump && ret && m_ras.size() > 0) begin
          void'(m_ras.pop_back());
        end
      end
      m_pc = nxt;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_req();
    stall = 0; redirect = 0; branch = 0; jump = 0; call = 0; ret = 0;
    redirect_addr = 0; branch_addr = 0; jump_addr = 0; ret_addr = 0;
  endtask

  task automatic test_reset();
    clear_req();
    rst = 1; start = 0; start2 = 0;
    tick(); tick();
    n_checks++; if (pc !== 32'h0) begin n_errors++; $display("FAIL reset_pc got %h exp 0", pc); end
    n_checks++; if (ras_count !== 4'd0) begin n_errors++; $display("FAIL reset_count got %0d exp 0", ras_count); end
    n_checks++; if (ras_ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf got %b exp 0", ras_ovf); end
    n_checks++; if (running !== 1'b0) begin n_errors++; $display("FAIL reset_running got %b exp 0", running); end
    n_checks++; if (pc2 !== 16'hFFF4) begin n_errors++; $display("FAIL reset_pc16 got %h exp fff4", pc2); end
    rst = 0;
    tick();
    n_checks++; if (pc !== 32'h0 || running !== 1'b0) begin n_errors++; $display("FAIL idle_hold got pc %h run %b exp 0 0", pc, running); end
  endtask

  task automatic test_sequence();
    logic [31:0] exp_seq [5];
    exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    start = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (pc !== exp_seq[i]) begin n_errors++; $display("FAIL seq_pc[%0d] got %h exp %h", i, pc, exp_seq[i]); end
    end
    n_checks++; if (running !== 1'b1) begin n_errors++; $display("FAIL seq_running got %b exp 1", running); end
  endtask

  task automatic test_branch_priority();
    branch = 1; branch_addr = 32'h100; jump = 1; call = 1; jump_addr = 32'h200;
    #1;
    n_checks++; if (pc_next !== 32'h100) begin n_errors++; $display("FAIL br_pc_next got %h exp 100", pc_next); end
    tick();
    clear_req();
    n_checks++; if (pc !== 32'h100) begin n_errors++; $display("FAIL br_pc got %h exp 100", pc); end
    n_checks++; if (ras_count !== 4'd0) begin n_errors++; $display("FAIL br_no_push got %0d exp 0", ras_count); end
    tick();
    n_checks++; if (pc !== 32'h104) begin n_errors++; $display("FAIL br_seq got %h exp 104", pc); end
  endtask

  task automatic test_stall_redirect();
    redirect = 1; redirect_addr = 32'h20;
    tick();
    clear_req();
    stall = 1; branch = 1; branch_addr = 32'h400;
    tick();
    n_checks++; if (pc !== 32'h20) begin n_errors++; $display("FAIL stall1 got %h exp 20", pc); end
    redirect = 1; redirect_addr = 32'h80;
    tick();
    redirect = 0;
    n_checks++; if (pc !== 32'h80) begin n_errors++; $display("FAIL stall_redirect got %h exp 80", pc); end
    tick();
    n_checks++; if (pc !== 32'h80) begin n_errors++; $display("FAIL stall3 got %h exp 80", pc); end
    clear_req();
  endtask

  task automatic test_ras_overflow();
    redirect = 1; redirect_addr = 32'h0;
    tick();
    clear_req();
    for (int i = 0; i < 9; i++) begin
      jump = 1; call = 1; jump_addr = 32'((i + 1) * 32'h100);
      tick();
      n_checks++; if (pc !== 32'((i + 1) * 32'h100)) begin n_errors++; $display("FAIL call_pc[%0d] got %h exp %h", i, pc, (i + 1) * 32'h100); end
    end
    clear_req();
    n_checks++; if (ras_count !== 4'd8) begin n_errors++; $display("FAIL ras_full got %0d exp 8", ras_count); end
    n_checks++; if (ras_ovf !== 1'b1) begin n_errors++; $display("FAIL ras_ovf got %b exp 1", ras_ovf); end
    ret = 1;
    for (int k = 0; k < 8; k++) begin
      ret_addr = $urandom;
      tick();
      n_checks++; if (pc !== 32'h804 - 32'(k * 32'h100)) begin n_errors++; $display("FAIL ret_pc[%0d] got %h exp %h", k, pc, 32'h804 - k * 32'h100); end
    end
    ret_addr = 32'h3C;
    tick();
    clear_req();
    n_checks++; if (pc !== 32'h3C) begin n_errors++; $display("FAIL ret_empty got %h exp 3c", pc); end
    n_checks++; if (ras_count !== 4'd0) begin n_errors++; $display("FAIL ret_empty_count got %0d exp 0", ras_count); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      jump = 1; call = 1; jump_addr = {$urandom} & 32'hFFFF_FFFC;
      tick();
    end
    clear_req();
    n_checks++; if (ras_count !== 4'd3) begin n_errors++; $display("FAIL mid_calls got %0d exp 3", ras_count); end
    rst = 1;
    tick();
    rst = 0;
    n_checks++; if (pc !== 32'h0 || ras_count !== 4'd0 || ras_ovf !== 1'b0 || running !== 1'b0) begin
      n_errors++; $display("FAIL mid_rst got pc %h cnt %0d ovf %b run %b exp 0 0 0 0", pc, ras_count, ras_ovf, running);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      jump = 1; call = 1; jump_addr = 32'h1000 + 32'(i * 16);
      tick();
    end
    clear_req();
    start = 0;
    tick();
    n_checks++; if (pc !== 32'h0 || ras_count !== 4'd0 || running !== 1'b0) begin
      n_errors++; $display("FAIL stop got pc %h cnt %0d run %b exp 0 0 0", pc, ras_count, running);
    end
  endtask

  task automatic test_wrap16();
    logic [15:0] exp16 [4];
    exp16 = '{16'hFFF4, 16'hFFF8, 16'hFFFC, 16'h0000};
    start2 = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (pc2 !== exp16[i]) begin n_errors++; $display("FAIL wrap16[%0d] got %h exp %h", i, pc2, exp16[i]); end
    end
    start2 = 0;
  endtask

  task automatic test_random();
    start = 1;
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 149) == 0);
      start    = ($urandom_range(0, 24) != 0);
      redirect = ($urandom_range(0, 15) == 0);
      stall    = ($urandom_range(0, 5) == 0);
      branch   = ($urandom_range(0, 6) == 0);
      jump     = ($urandom_range(0, 3) == 0);
      call     = jump ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      ret      = (jump && call) ? 1'b0 : ($urandom_range(0, 2) == 0);
      redirect_addr = $urandom; branch_addr = $urandom;
      jump_addr = $urandom; ret_addr = $urandom;
      #1;
      if (!rst) begin
        n_checks++; if (pc_next !== predict_pc()) begin n_errors++; $display("FAIL rnd_pc_next[%0d] got %h exp %h", c, pc_next, predict_pc()); end
      end
      tick();
      n_checks++;
      if (pc !== m_pc || running !== m_run || ras_count !== 4'(m_ras.size()) || ras_ovf !== m_ovf) begin
        n_errors++;
        $display("FAIL rnd_state[%0d] got pc %h run %b cnt %0d ovf %b exp %h %b %0d %b",
                 c, pc, running, ras_count, ras_ovf, m_pc, m_run, m_ras.size(), m_ovf);
      end
    end
    clear_req();
    rst = 0;
  endtask

  initial begin
    clear_req();
    rst = 1; start = 0; start2 = 0;
    test_reset();
    test_sequence();
    test_branch_priority();
    test_stall_redirect();
    test_ras_overflow();
    test_reset_mid();
    test_wrap16();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
